// File: rtl/mips_defs_pkg.sv
// Shared definitions for the fetch stage and the downstream instruction classifier.
//   - Store geometry: DEPTH words of IW bits, addressed by AW bits. PCW is wide
//     enough to hold the value DEPTH, so a run length of DEPTH is representable.
//   - Fetch FSM state encoding.
//   - MIPS primary opcode field values used by the classifier.
package mips_defs_pkg;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = 32;
    localparam int PCW   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } fetch_state_e;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

endpackage

// File: rtl/inst_rom.sv
// DEPTH x IW instruction store with one synchronous write port and one
// synchronous read port.
// The array itself has no reset, so its contents survive rst_n. Only the read
// data register is reset, because it drives the fetch unit's inst_out directly.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   i_wr_en/addr/data   write port, commits on posedge
//   i_rd_en, i_rd_addr  read strobe and address
//   o_rd_data           registered read data, updated only when i_rd_en=1
module inst_rom #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int IW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [IW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [IW-1:0] o_rd_data
);

    logic [IW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: holds a loadable instruction store and, on start, streams words
// 0..len-1 to the consumer, one per valid/ready transfer, with each word's
// store index on pc_out.
//
// Handshake: inst_valid rises with a word and stays high, with inst_out and
// pc_out unchanged, until the cycle in which inst_ready is also high; that
// cycle is the transfer. inst_ready is ignored while inst_valid is low.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   wr_en/wr_addr/wr_data   store write, honoured only in IDLE or DONE
//   start, prog_len         begin a run of min(prog_len, DEPTH) words (IDLE/DONE only)
//   inst_out, pc_out        presented word and its store index
//   inst_valid, inst_ready  consumer handshake
//   busy                    run in progress (READ or PRESENT)
//   done                    run complete, held until the next start
//   dbg_state               current FSM state
module inst_fetch_unit
    import mips_defs_pkg::*;
#(
    parameter int DEPTH = mips_defs_pkg::DEPTH,
    parameter int AW    = mips_defs_pkg::AW,
    parameter int IW    = mips_defs_pkg::IW,
    parameter int PCW   = mips_defs_pkg::PCW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [IW-1:0]  wr_data,
    input  logic           start,
    input  logic [PCW-1:0] prog_len,
    output logic [IW-1:0]  inst_out,
    output logic           inst_valid,
    input  logic           inst_ready,
    output logic [PCW-1:0] pc_out,
    output logic           busy,
    output logic           done,
    output fetch_state_e   dbg_state
);

    fetch_state_e   r_state;
    fetch_state_e   w_state_nxt;
    logic [PCW-1:0] r_len;
    logic [PCW-1:0] r_pc;
    logic [PCW-1:0] r_pc_out;
    logic           r_valid;

    logic           w_idle_like;
    logic           w_accept_start;
    logic           w_xfer;
    logic           w_rd_en;
    logic           w_store_wr_en;
    logic [PCW-1:0] w_len_clamped;
    logic [PCW-1:0] w_pc_inc;
    logic [IW-1:0]  w_rd_data;

    // Store and run control are only touched between runs.
    assign w_idle_like    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept_start = w_idle_like && start;
    assign w_store_wr_en  = w_idle_like && wr_en;
    assign w_rd_en        = (r_state == ST_READ);
    assign w_xfer         = (r_state == ST_PRESENT) && inst_ready;
    assign w_len_clamped  = (prog_len > PCW'(DEPTH)) ? PCW'(DEPTH) : prog_len;
    assign w_pc_inc       = r_pc + PCW'(1);

    // Inside a run r_pc < r_len <= DEPTH, so its low AW bits address the store.
    inst_rom #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_rom (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_store_wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_pc[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = (w_len_clamped == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (inst_ready) begin
                    w_state_nxt = (w_pc_inc == r_len) ? ST_DONE : ST_READ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len    <= '0;
            r_pc     <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_accept_start) begin
                r_len <= w_len_clamped;
                r_pc  <= '0;
            end
            // The store read register loads in this same cycle, so pc_out and
            // inst_out change together.
            if (r_state == ST_READ) begin
                r_pc_out <= r_pc;
                r_valid  <= 1'b1;
            end
            if (w_xfer) begin
                r_valid <= 1'b0;
                r_pc    <= w_pc_inc;
            end
        end
    end

    assign inst_out   = w_rd_data;
    assign inst_valid = r_valid;
    assign pc_out     = r_pc_out;
    assign busy       = (r_state == ST_READ) || (r_state == ST_PRESENT);
    assign done       = (r_state == ST_DONE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  import mips_defs_pkg::*;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [IW-1:0]  wr_data;
  logic           start;
  logic [PCW-1:0] prog_len;
  logic [IW-1:0]  inst_out;
  logic           inst_valid;
  logic           inst_ready;
  logic [PCW-1:0] pc_out;
  logic           busy;
  logic           done;
  fetch_state_e   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  inst_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .prog_len   (prog_len),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc_out     (pc_out),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  localparam int EW = PCW + IW;
  logic [EW-1:0] exp_q[$];
  logic [IW-1:0] model_mem [DEPTH];
  int checks = 0;
  int failures = 0;
  int xfer_count = 0;
  bit gap_en = 0;
  bit have_prev = 0;
  int prev_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every transfer pops one expected {pc, word}.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL xfer_unexpected: got pc=%0d word=0x%08h expected no transfer", pc_out, inst_out);
      end else begin
        check("xfer_word", {pc_out, inst_out}, exp_q.pop_front());
      end
      xfer_count++;
      if (gap_en && have_prev) check("xfer_gap", 64'(cyc - prev_cyc), 64'd2);
      prev_cyc = cyc;
      have_prev = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [IW-1:0] data);
    wr_en = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Pushes the first n_exp model words, then pulses start for one cycle.
  task automatic start_run(input int len, input int n_exp);
    for (int i = 0; i < n_exp; i++) exp_q.push_back({PCW'(i), model_mem[i]});
    start = 1'b1;
    prog_len = PCW'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic wait_present(input int pc);
    int n = 0;
    while (!(inst_valid && pc_out == PCW'(pc)) && n < 200) begin
      tick();
      n++;
    end
    check("wait_present", 64'(inst_valid && pc_out == PCW'(pc)), 64'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n0;
    bit valid_seen;
    model_mem[0] = 32'h20043456; model_mem[1] = 32'h2005FFFF;
    model_mem[2] = 32'h00A43020; model_mem[3] = 32'h20030007;
    model_mem[4] = 32'h00663004; model_mem[5] = 32'h00031842;
    model_mem[6] = 32'h8C859ABC; model_mem[7] = 32'h08123456;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; prog_len = '0; inst_ready = 1'b1;
    tick(); tick();
    check("rst_inst_out", 64'(inst_out), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_pc_out", 64'(pc_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) write_word(i, model_mem[i]);

    // 1: full run with ready held high, two cycles per transfer
    gap_en = 1; have_prev = 0;
    start_run(8, 8);
    check("t1_busy_read", 64'(busy), 64'd1);
    check("t1_valid_read", 64'(inst_valid), 64'd0);
    tick();
    check("t1_valid_latency", 64'(inst_valid), 64'd1);
    check("t1_first_pc", 64'(pc_out), 64'd0);
    wait_done("t1_done");
    gap_en = 0;
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_state_end", 64'(dbg_state), 64'(ST_DONE));
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // 2: backpressure on word 2
    start_run(8, 8);
    wait_present(1);
    tick();
    inst_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_valid", 64'(inst_valid), 64'd1);
      check("t2_hold_word", 64'(inst_out), 64'h00A43020);
      check("t2_hold_pc", 64'(pc_out), 64'd2);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    check("t2_released", 64'(inst_valid), 64'd0);
    check("t2_busy", 64'(busy), 64'd1);
    wait_done("t2_done");
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 4: write while busy is dropped; write together with start commits
    start_run(8, 8);
    write_word(3, 32'hDEADBEEF);
    wait_done("t4a_done");
    check("t4a_drained", 64'(exp_q.size()), 64'd0);
    model_mem[3] = 32'hDEADBEEF;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEADBEEF;
    start_run(8, 8);
    wr_en = 1'b0;
    wait_done("t4b_done");
    check("t4b_drained", 64'(exp_q.size()), 64'd0);

    // 5: async reset while presenting word 4
    start_run(8, 8);
    wait_present(3);
    tick();
    inst_ready = 1'b0;
    tick();
    check("t5_pre_pc", 64'(pc_out), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_inst_out", 64'(inst_out), 64'd0);
    check("t5_rst_valid", 64'(inst_valid), 64'd0);
    check("t5_rst_pc_out", 64'(pc_out), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    tick();
    check("t5_idle", 64'(dbg_state), 64'(ST_IDLE));

    // 3a: zero-length run from IDLE
    start_run(0, 0);
    check("t3_len0_done", 64'(done), 64'd1);
    check("t3_len0_busy", 64'(busy), 64'd0);
    valid_seen = 0;
    for (int k = 0; k < 4; k++) begin
      valid_seen |= inst_valid;
      tick();
    end
    check("t3_len0_no_valid", 64'(valid_seen), 64'd0);

    // 5 cont.: replay from pc 0, store intact after reset
    start_run(8, 8);
    wait_done("t5_replay_done");
    check("t5_replay_drained", 64'(exp_q.size()), 64'd0);

    // 3b: prog_len above DEPTH is clamped
    n0 = xfer_count;
    start_run(12, 8);
    wait_done("t3_clamp_done");
    check("t3_clamp_count", 64'(xfer_count - n0), 64'd8);
    check("t3_clamp_drained", 64'(exp_q.size()), 64'd0);

    // 6: start while busy ignored; start in DONE restarts
    n0 = xfer_count;
    start_run(4, 4);
    wait_present(1);
    start = 1'b1; prog_len = 4'd2;
    tick();
    start = 1'b0;
    wait_done("t6_done");
    check("t6_count", 64'(xfer_count - n0), 64'd4);
    check("t6_drained", 64'(exp_q.size()), 64'd0);
    start_run(3, 3);
    check("t6_restart_done", 64'(done), 64'd0);
    check("t6_restart_busy", 64'(busy), 64'd1);
    wait_done("t6_rerun_done");
    check("t6_rerun_drained", 64'(exp_q.size()), 64'd0);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, expected finish before 200000");
    $fatal(1);
  end

endmodule
